inst_fetch_queue: RTL

- Parametrised, writable instruction memory with a sequential prefetcher and an output queue using a valid/ready handshake.
- Replaces the fixed combinational instruction ROM in the IF stage.
- Fetches word-aligned instructions ahead of the pipeline and buffers up to QUEUE_DEPTH of them.
- Supports branch/jump redirect with flush, and runtime program loading through a write port.

---
 rtl/inst_fetch_queue.sv | 107 ++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - writable instruction memory with sequential prefetcher and show-ahead valid/ready queue
module inst_fetch_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_WORDS   = 256,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_adrs,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_adrs,
  input  logic                  inst_ready,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_adrs
);

  localparam int QW  = $clog2(QUEUE_DEPTH);
  localparam int CW  = QW + 1;
  localparam int IW  = $clog2(MEM_WORDS);
  localparam int AW1 = ADDR_WIDTH + 1;
  // Byte-address limit; comparing full addresses avoids truncating the word index.
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = AW1'(MEM_WORDS) << 2;

  logic [DATA_WIDTH-1:0] mem    [MEM_WORDS];
  logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_adrs [QUEUE_DEPTH];

  logic [QW-1:0]         head;
  logic [QW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] fetch_ptr;
  logic [DATA_WIDTH-1:0] last_inst;
  logic [ADDR_WIDTH-1:0] last_adrs;
  logic [DATA_WIDTH-1:0] fetch_word;
  logic [ADDR_WIDTH-1:0] redirect_aligned;
  logic                  prog_in_range;
  logic                  fetch_in_range;
  logic                  full;
  logic                  pop;
  logic                  push;

  assign prog_in_range    = {1'b0, prog_adrs} < MEM_BYTES;
  assign fetch_in_range   = {1'b0, fetch_ptr} < MEM_BYTES;
  assign redirect_aligned = redirect_adrs & ~ADDR_WIDTH'(3);

  always_ff @(posedge clk) begin
    if (prog_we && prog_in_range) begin
      mem[prog_adrs[IW+1:2]] <= prog_data;
    end
  end

  // Combinational read sees the pre-edge contents, so a same-cycle write queues the old word.
  assign fetch_word = fetch_in_range ? mem[fetch_ptr[IW+1:2]] : '0;

  assign full       = (count == CW'(QUEUE_DEPTH));
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready && !redirect;
  assign push       = fetch_en && !redirect && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[tail] <= fetch_word;
      q_adrs[tail] <= fetch_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_ptr <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      last_inst <= '0;
      last_adrs <= '0;
    end else if (redirect) begin
      fetch_ptr <= redirect_aligned;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
    end else begin
      if (push) begin
        tail      <= tail + QW'(1);
        fetch_ptr <= fetch_ptr + ADDR_WIDTH'(4);
      end
      if (pop) begin
        head      <= head + QW'(1);
        last_inst <= q_data[head];
        last_adrs <= q_adrs[head];
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Empty queue keeps presenting the most recently consumed entry.
  assign inst      = inst_valid ? q_data[head] : last_inst;
  assign inst_adrs = inst_valid ? q_adrs[head] : last_adrs;

endmodule
